// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port RAM between instruction fetch (IF) and the
//   load/store port driven by inst_decode. Each granted request is registered
//   onto the mem_* outputs. The arbiter then waits for mem_ready_i and returns
//   read data or a write acknowledge as a one-cycle pulse. A one-cycle bubble
//   follows, and then the arbiter goes back to sampling requests.
//
//   pipeline_stall_o is a registered output. This avoids a combinational
//   loop through the decoder's stall gating.
//
// Optional feature (macro ARB_FAIR_EN)
//   When this macro is defined, a 3-bit starve counter counts consecutive LS
//   grants made while IF was also requesting. When the count reaches
//   STARVE_LIMIT, IF is granted ahead of any LS request. Without the macro
//   the arbiter uses strict priority store > load > IF, and no counter is
//   built.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   if_req_i/if_addr_i            IF read request and address
//   if_rdata_o/if_rvalid_o        IF read data and one-cycle valid pulse
//   ls_rd_req_i/ls_rd_addr_i      load request and address
//   ls_wr_req_i/ls_wr_addr_i      store request and address
//   ls_wr_data_i/ls_wr_en_i       store data (lane-aligned) and byte enables
//   ls_rdata_o/ls_rvalid_o        load data and one-cycle valid pulse
//   ls_wack_o                     store-complete pulse
//   mem_req_o/mem_we_o            RAM request (held until ready) and byte write enables
//   mem_addr_o/mem_wdata_o        RAM address and write data
//   mem_rdata_i/mem_ready_i       RAM read data and handshake
//   pipeline_stall_o              high while an LS access is in flight
// -----------------------------------------------------------------------------
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | sample requests, grant store > load > IF (fairness may override)
//  BUSY_IF | IF read outstanding, mem_* held until mem_ready_i
//  BUSY_LD | load outstanding, stall asserted
//  BUSY_ST | store outstanding, stall asserted
//  DONE    | one bubble cycle, request inputs ignored
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_rvalid_o,
  input  logic                  ls_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] ls_rd_addr_i,
  input  logic                  ls_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] ls_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wr_data_i,
  input  logic [3:0]            ls_wr_en_i,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ls_rvalid_o,
  output logic                  ls_wack_o,
  output logic                  mem_req_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  pipeline_stall_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_LD = 3'd2,
    S_BUSY_ST = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_mem_req_nxt;
  logic [3:0]            w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
  logic [DATA_WIDTH-1:0] w_if_rdata_nxt;
  logic [DATA_WIDTH-1:0] w_ls_rdata_nxt;
  logic                  w_if_rvalid_nxt;
  logic                  w_ls_rvalid_nxt;
  logic                  w_ls_wack_nxt;
  logic                  w_stall_nxt;

  logic                  w_force_if;
  logic                  w_grant_st;
  logic                  w_grant_ld;
  logic                  w_grant_if;

`ifdef ARB_FAIR_EN
  logic [2:0] r_starve_cnt;
  logic [2:0] w_starve_cnt_nxt;

  assign w_force_if = if_req_i && (r_starve_cnt >= 3'(STARVE_LIMIT));

  // The counter only advances on IDLE-cycle grants. It saturates so that a
  // limit of 7 cannot wrap back to zero.
  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (r_state == S_IDLE) begin
      if (w_grant_if) begin
        w_starve_cnt_nxt = 3'd0;
      end else if (w_grant_st || w_grant_ld) begin
        if (if_req_i) begin
          w_starve_cnt_nxt = (r_starve_cnt == 3'd7) ? r_starve_cnt : r_starve_cnt + 3'd1;
        end else begin
          w_starve_cnt_nxt = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else begin
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end
`else
  logic [2:0] w_unused_starve_limit;
  assign w_unused_starve_limit = 3'(STARVE_LIMIT);
  assign w_force_if = 1'b0;
`endif

  // A simultaneous load and store never comes from the decoder. If it does
  // happen, the store wins and the load is dropped.
  assign w_grant_st = ls_wr_req_i && !w_force_if;
  assign w_grant_ld = ls_rd_req_i && !ls_wr_req_i && !w_force_if;
  assign w_grant_if = if_req_i && !w_grant_st && !w_grant_ld;

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = mem_req_o;
    w_mem_we_nxt    = mem_we_o;
    w_mem_addr_nxt  = mem_addr_o;
    w_mem_wdata_nxt = mem_wdata_o;
    w_if_rdata_nxt  = if_rdata_o;
    w_ls_rdata_nxt  = ls_rdata_o;
    w_if_rvalid_nxt = 1'b0;
    w_ls_rvalid_nxt = 1'b0;
    w_ls_wack_nxt   = 1'b0;
    w_stall_nxt     = pipeline_stall_o;

    case (r_state)
      S_IDLE: begin
        if (w_grant_st) begin
          w_state_nxt     = S_BUSY_ST;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = ls_wr_en_i;
          w_mem_addr_nxt  = ls_wr_addr_i;
          w_mem_wdata_nxt = ls_wr_data_i;
          w_stall_nxt     = 1'b1;
        end else if (w_grant_ld) begin
          w_state_nxt     = S_BUSY_LD;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 4'b0000;
          w_mem_addr_nxt  = ls_rd_addr_i;
          w_mem_wdata_nxt = '0;
          w_stall_nxt     = 1'b1;
        end else if (w_grant_if) begin
          w_state_nxt     = S_BUSY_IF;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 4'b0000;
          w_mem_addr_nxt  = if_addr_i;
          w_mem_wdata_nxt = '0;
        end
      end

      S_BUSY_IF: begin
        if (mem_ready_i) begin
          w_state_nxt     = S_DONE;
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 4'b0000;
          w_if_rdata_nxt  = mem_rdata_i;
          w_if_rvalid_nxt = 1'b1;
          w_stall_nxt     = 1'b0;
        end
      end

      S_BUSY_LD: begin
        if (mem_ready_i) begin
          w_state_nxt     = S_DONE;
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 4'b0000;
          w_ls_rdata_nxt  = mem_rdata_i;
          w_ls_rvalid_nxt = 1'b1;
          w_stall_nxt     = 1'b0;
        end
      end

      S_BUSY_ST: begin
        if (mem_ready_i) begin
          w_state_nxt   = S_DONE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 4'b0000;
          w_ls_wack_nxt = 1'b1;
          w_stall_nxt   = 1'b0;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      mem_req_o        <= 1'b0;
      mem_we_o         <= 4'b0000;
      mem_addr_o       <= '0;
      mem_wdata_o      <= '0;
      if_rdata_o       <= '0;
      ls_rdata_o       <= '0;
      if_rvalid_o      <= 1'b0;
      ls_rvalid_o      <= 1'b0;
      ls_wack_o        <= 1'b0;
      pipeline_stall_o <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      mem_req_o        <= w_mem_req_nxt;
      mem_we_o         <= w_mem_we_nxt;
      mem_addr_o       <= w_mem_addr_nxt;
      mem_wdata_o      <= w_mem_wdata_nxt;
      if_rdata_o       <= w_if_rdata_nxt;
      ls_rdata_o       <= w_ls_rdata_nxt;
      if_rvalid_o      <= w_if_rvalid_nxt;
      ls_rvalid_o      <= w_ls_rvalid_nxt;
      ls_wack_o        <= w_ls_wack_nxt;
      pipeline_stall_o <= w_stall_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int STARVE = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_rvalid_o;
  logic          ls_rd_req_i;
  logic [AW-1:0] ls_rd_addr_i;
  logic          ls_wr_req_i;
  logic [AW-1:0] ls_wr_addr_i;
  logic [DW-1:0] ls_wr_data_i;
  logic [3:0]    ls_wr_en_i;
  logic [DW-1:0] ls_rdata_o;
  logic          ls_rvalid_o;
  logic          ls_wack_o;
  logic          mem_req_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          pipeline_stall_o;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .ls_rd_req_i(ls_rd_req_i), .ls_rd_addr_i(ls_rd_addr_i),
    .ls_wr_req_i(ls_wr_req_i), .ls_wr_addr_i(ls_wr_addr_i),
    .ls_wr_data_i(ls_wr_data_i), .ls_wr_en_i(ls_wr_en_i),
    .ls_rdata_o(ls_rdata_o), .ls_rvalid_o(ls_rvalid_o), .ls_wack_o(ls_wack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .pipeline_stall_o(pipeline_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. It tracks one outstanding access and the quiet cycle
  // that follows it, and it predicts the registered outputs after each edge.
  typedef enum int {K_NONE, K_IF, K_LD, K_ST} kind_t;
  bit            m_open;
  bit            m_cool;
  kind_t         m_kind;
  int            m_streak;
  logic          e_req;
  logic [3:0]    e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_ifv, e_lsv, e_wack, e_stall;
  logic [DW-1:0] e_if_rdata, e_ls_rdata;

  task automatic model_edge();
    kind_t pick;
    if (rst) begin
      m_open = 0; m_cool = 0; m_kind = K_NONE; m_streak = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_ifv = 0; e_lsv = 0; e_wack = 0; e_stall = 0;
      e_if_rdata = 0; e_ls_rdata = 0;
    end else begin
      e_ifv = 0; e_lsv = 0; e_wack = 0;
      if (m_open) begin
        if (mem_ready_i) begin
          m_open = 0; m_cool = 1;
          e_req = 0; e_we = 0; e_stall = 0;
          if (m_kind == K_IF) begin e_ifv = 1; e_if_rdata = mem_rdata_i; end
          if (m_kind == K_LD) begin e_lsv = 1; e_ls_rdata = mem_rdata_i; end
          if (m_kind == K_ST) e_wack = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else begin
        pick = K_NONE;
        if (FAIR && if_req_i && m_streak >= STARVE) pick = K_IF;
        else if (ls_wr_req_i) pick = K_ST;
        else if (ls_rd_req_i) pick = K_LD;
        else if (if_req_i) pick = K_IF;
        if (pick != K_NONE) begin
          m_open = 1; m_kind = pick; e_req = 1;
          case (pick)
            K_ST:    begin e_we = ls_wr_en_i; e_addr = ls_wr_addr_i; e_wdata = ls_wr_data_i; e_stall = 1; end
            K_LD:    begin e_we = 0; e_addr = ls_rd_addr_i; e_stall = 1; end
            default: begin e_we = 0; e_addr = if_addr_i; end
          endcase
          if (pick == K_IF || !if_req_i) m_streak = 0;
          else m_streak++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    rst = 0; if_req_i = 0; if_addr_i = 0; ls_rd_req_i = 0; ls_rd_addr_i = 0;
    ls_wr_req_i = 0; ls_wr_addr_i = 0; ls_wr_data_i = 0; ls_wr_en_i = 0;
    mem_rdata_i = 0; mem_ready_i = 1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'(e_req));
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'(e_we));
    if (e_req) chk({tag, "_mem_addr"}, mem_addr_o, e_addr);
    if (e_req && e_we != 0) chk({tag, "_mem_wdata"}, mem_wdata_o, e_wdata);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid_o), 32'(e_ifv));
    chk({tag, "_ls_rvalid"}, 32'(ls_rvalid_o), 32'(e_lsv));
    chk({tag, "_ls_wack"}, 32'(ls_wack_o), 32'(e_wack));
    chk({tag, "_stall"}, 32'(pipeline_stall_o), 32'(e_stall));
    chk({tag, "_if_rdata"}, if_rdata_o, e_if_rdata);
    chk({tag, "_ls_rdata"}, ls_rdata_o, e_ls_rdata);
  endtask

  typedef struct {
    logic [31:0] rst, if_req, if_addr, ls_rd, ls_wr, rd_addr, wr_addr, wdata, en, ready, rdata;
    logic [31:0] x_req, x_we, chk_addr, x_addr, chk_wd, x_wdata, x_ifv, x_lsv, x_wack, x_stall, x_if_rdata, x_ls_rdata;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] grants[$];
    logic        prev_req;
    int          budget;

    // Columns: rst if_req if_addr ls_rd ls_wr rd_addr wr_addr wdata en ready rdata |
    //          req we chk_addr addr chk_wd wdata ifv lsv wack stall if_rdata ls_rdata
    tbl[0]  = '{1, 0, 0,     0, 0, 0,     0,     0,          0,  0, 0,            0, 0,  1, 0,     1, 0,          0, 0, 0, 0, 0,            0};
    tbl[1]  = '{0, 1, 'h100, 0, 0, 0,     0,     0,          0,  1, 'h00500093,   1, 0,  1, 'h100, 0, 0,          0, 0, 0, 0, 0,            0};
    tbl[2]  = '{0, 0, 'h100, 0, 0, 0,     0,     0,          0,  1, 'h00500093,   0, 0,  0, 0,     0, 0,          1, 0, 0, 0, 'h00500093,   0};
    tbl[3]  = '{0, 0, 0,     0, 0, 0,     0,     0,          0,  1, 0,            0, 0,  0, 0,     0, 0,          0, 0, 0, 0, 'h00500093,   0};
    tbl[4]  = '{0, 1, 'h100, 0, 1, 0,     'h204, 'h0000AB00, 2,  1, 0,            1, 2,  1, 'h204, 1, 'h0000AB00, 0, 0, 0, 1, 'h00500093,   0};
    tbl[5]  = '{0, 1, 'h100, 0, 0, 0,     0,     0,          0,  1, 0,            0, 0,  0, 0,     0, 0,          0, 0, 1, 0, 'h00500093,   0};
    tbl[6]  = '{0, 1, 'h100, 0, 0, 0,     0,     0,          0,  1, 0,            0, 0,  0, 0,     0, 0,          0, 0, 0, 0, 'h00500093,   0};
    tbl[7]  = '{0, 1, 'h100, 0, 0, 0,     0,     0,          0,  1, 'h11112222,   1, 0,  1, 'h100, 0, 0,          0, 0, 0, 0, 'h00500093,   0};
    tbl[8]  = '{0, 0, 0,     0, 0, 0,     0,     0,          0,  1, 'h11112222,   0, 0,  0, 0,     0, 0,          1, 0, 0, 0, 'h11112222,   0};
    tbl[9]  = '{0, 0, 0,     0, 0, 0,     0,     0,          0,  1, 0,            0, 0,  0, 0,     0, 0,          0, 0, 0, 0, 'h11112222,   0};
    tbl[10] = '{0, 0, 0,     1, 1, 'h400, 'h408, 'hCAFEF00D, 15, 1, 0,            1, 15, 1, 'h408, 1, 'hCAFEF00D, 0, 0, 0, 1, 'h11112222,   0};
    tbl[11] = '{0, 0, 0,     0, 0, 0,     0,     0,          0,  1, 'h55555555,   0, 0,  0, 0,     0, 0,          0, 0, 1, 0, 'h11112222,   0};
    tbl[12] = '{0, 0, 0,     0, 0, 0,     0,     0,          0,  1, 'h55555555,   0, 0,  0, 0,     0, 0,          0, 0, 0, 0, 'h11112222,   0};

    idle_in();
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst[0]; if_req_i = tbl[i].if_req[0]; if_addr_i = tbl[i].if_addr;
      ls_rd_req_i = tbl[i].ls_rd[0]; ls_wr_req_i = tbl[i].ls_wr[0];
      ls_rd_addr_i = tbl[i].rd_addr; ls_wr_addr_i = tbl[i].wr_addr;
      ls_wr_data_i = tbl[i].wdata; ls_wr_en_i = tbl[i].en[3:0];
      mem_ready_i = tbl[i].ready[0]; mem_rdata_i = tbl[i].rdata;
      step();
      chk($sformatf("tbl%0d_mem_req", i), 32'(mem_req_o), tbl[i].x_req);
      chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we_o), tbl[i].x_we);
      if (tbl[i].chk_addr[0]) chk($sformatf("tbl%0d_mem_addr", i), mem_addr_o, tbl[i].x_addr);
      if (tbl[i].chk_wd[0]) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata_o, tbl[i].x_wdata);
      chk($sformatf("tbl%0d_if_rvalid", i), 32'(if_rvalid_o), tbl[i].x_ifv);
      chk($sformatf("tbl%0d_ls_rvalid", i), 32'(ls_rvalid_o), tbl[i].x_lsv);
      chk($sformatf("tbl%0d_ls_wack", i), 32'(ls_wack_o), tbl[i].x_wack);
      chk($sformatf("tbl%0d_stall", i), 32'(pipeline_stall_o), tbl[i].x_stall);
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata_o, tbl[i].x_if_rdata);
      chk($sformatf("tbl%0d_ls_rdata", i), ls_rdata_o, tbl[i].x_ls_rdata);
    end

    // Wait states: the load is held for four cycles and then completes.
    idle_in();
    ls_rd_req_i = 1; ls_rd_addr_i = 'h300; mem_ready_i = 0;
    step();
    ls_rd_req_i = 0; ls_rd_addr_i = 0;
    for (int c = 0; c < 4; c++) begin
      chk("ws_mem_req", 32'(mem_req_o), 1);
      chk("ws_mem_addr", mem_addr_o, 'h300);
      chk("ws_mem_we", 32'(mem_we_o), 0);
      chk("ws_stall", 32'(pipeline_stall_o), 1);
      chk("ws_ls_rvalid", 32'(ls_rvalid_o), 0);
      if (c < 3) step();
    end
    mem_ready_i = 1; mem_rdata_i = 'hDEADBEEF;
    step();
    chk("ws_ls_rvalid_pulse", 32'(ls_rvalid_o), 1);
    chk("ws_ls_rdata", ls_rdata_o, 'hDEADBEEF);
    chk("ws_stall_clear", 32'(pipeline_stall_o), 0);
    chk("ws_mem_req_clear", 32'(mem_req_o), 0);
    mem_rdata_i = 0;
    step();
    chk("ws_ls_rvalid_once", 32'(ls_rvalid_o), 0);
    chk("ws_ls_rdata_hold", ls_rdata_o, 'hDEADBEEF);
    step();

    // Reset while a load is outstanding.
    idle_in();
    ls_rd_req_i = 1; ls_rd_addr_i = 'h500; mem_ready_i = 0;
    step();
    chk("rst_pre_mem_req", 32'(mem_req_o), 1);
    ls_rd_req_i = 0; rst = 1; mem_ready_i = 1; mem_rdata_i = 'h77;
    step();
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_stall", 32'(pipeline_stall_o), 0);
    chk("rst_ls_rdata", ls_rdata_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst_no_ls_rvalid", 32'(ls_rvalid_o), 0);
      chk("rst_no_mem_req", 32'(mem_req_o), 0);
    end

    // Starvation: continuous loads with IF held high.
    idle_in();
    ls_rd_req_i = 1; ls_rd_addr_i = 'h600; if_req_i = 1; if_addr_i = 'h700; mem_ready_i = 1;
    prev_req = 0;
    budget = 0;
    while (grants.size() < 6 && budget < 40) begin
      step();
      if (mem_req_o && !prev_req) grants.push_back(mem_addr_o);
      prev_req = mem_req_o;
      budget++;
    end
    chk("starve_grant_count", grants.size(), 6);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("starve_grant%0d", k), grants[k], (FAIR && k == STARVE) ? 'h700 : 'h600);

    // Randomized traffic against the reference model.
    idle_in();
    rst = 1;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 127) == 0);
      if_req_i     = ($urandom_range(0, 3) != 0);
      if_addr_i    = $urandom;
      ls_rd_req_i  = ($urandom_range(0, 2) == 0);
      ls_rd_addr_i = $urandom;
      ls_wr_req_i  = ($urandom_range(0, 3) == 0);
      ls_wr_addr_i = $urandom;
      ls_wr_data_i = $urandom;
      ls_wr_en_i   = 4'($urandom_range(1, 15));
      mem_ready_i  = ($urandom_range(0, 2) != 0);
      mem_rdata_i  = $urandom;
      step();
      chk_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
